mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide scheduler beside the Execute stage of the pipelined MIPS core. Accepts one HI/LO operation per cycle from E, runs it for a fixed latency, and commits the 64-bit result to HI/LO. Raises a busy/stall indication so the hazard unit can hold any dependent HI/LO instruction in D. Honours the pipeline flush so an instruction cancelled by an exception or interrupt never touches HI/LO.

---
 rtl/mdu_defs.sv | 45 ++++
 rtl/mdu_arith.sv | 47 ++++
 rtl/mdu_ctrl.sv | 133 +++++++++++++
 tb/tb_mdu_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared opcode, state and commit-kind definitions for the HI/LO multiply/divide unit.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU opcodes to the multi-cycle set.
package mdu_defs;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // How the pending value lands in {hi,lo} when the counter expires.
  typedef enum logic [1:0] {
    C_WRITE = 2'd0,
    C_HOLD  = 2'd1,
    C_ADD   = 2'd2,
    C_SUB   = 2'd3
  } commit_e;

  function automatic logic is_multi_op(input logic [3:0] op);
    logic multi;
    multi = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: multi = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: multi = 1'b1;
`endif
      default: multi = 1'b0;
    endcase
    return multi;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO datapath: 64-bit product or {remainder, quotient} from rs/rt,
// plus a divide-by-zero flag.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic [31:0]        divisor_s;
  logic [31:0]        divisor_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  // Divisors are forced to 1 for the zero and INT_MIN/-1 cases so the dividers never
  // see an undefined operation; those results are substituted below.
  always_comb begin
    div_zero  = (rt == 32'd0);
    div_ovf   = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    prod_s    = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u    = {32'd0, rs} * {32'd0, rt};
    divisor_s = (div_zero || div_ovf) ? 32'd1 : rt;
    divisor_u = div_zero ? 32'd1 : rt;
    quot_s    = $signed(rs) / $signed(divisor_s);
    rem_s     = $signed(rs) % $signed(divisor_s);
    quot_u    = rs / divisor_u;
    rem_u     = rs % divisor_u;

    result = 64'd0;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB:    result = prod_s;
      OP_MULTU, OP_MADDU, OP_MSUBU: result = prod_u;
      OP_DIV:  result = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quot_s};
      OP_DIVU: result = {rem_u, quot_u};
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO scheduler: fixed-latency multiply/divide with busy/stall and flush handling.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate into {hi,lo}.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       pending_q, pending_d;
  commit_e           kind_q, kind_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [63:0]       arith_result;
  logic              arith_div_zero;
  logic              last_cycle;
  logic              accept;

  mdu_arith u_arith (
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  // cnt is 1 only in RUN, so the final busy cycle can also take the next operation.
  assign last_cycle = (cnt_q == CNT_W'(1));
  assign accept     = start & ~flush & ((state_q == S_IDLE) | last_cycle);
  assign busy       = (state_q == S_RUN);
  assign stall      = busy | (start & ~flush & is_multi_op(op));
  assign hi         = hi_q;
  assign lo         = lo_q;

  // Commit of the running operation is evaluated first so an operation issued on the
  // same edge (including MTHI/MTLO) sees and overrides the committed value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    kind_d    = kind_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == S_RUN) begin
      if (last_cycle) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        case (kind_q)
          C_WRITE: {hi_d, lo_d} = pending_q;
`ifdef MDU_MADD_EN
          C_ADD:   {hi_d, lo_d} = {hi_q, lo_q} + pending_q;
          C_SUB:   {hi_d, lo_d} = {hi_q, lo_q} - pending_q;
`endif
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          pending_d = arith_result;
          kind_d    = C_WRITE;
          cnt_d     = CNT_W'(MULT_CYCLES);
          state_d   = S_RUN;
        end
        OP_DIV, OP_DIVU: begin
          pending_d = arith_result;
          kind_d    = arith_div_zero ? C_HOLD : C_WRITE;
          cnt_d     = CNT_W'(DIV_CYCLES);
          state_d   = S_RUN;
        end
`ifdef MDU_MADD_EN
        OP_MADD, OP_MADDU: begin
          pending_d = arith_result;
          kind_d    = C_ADD;
          cnt_d     = CNT_W'(MULT_CYCLES);
          state_d   = S_RUN;
        end
        OP_MSUB, OP_MSUBU: begin
          pending_d = arith_result;
          kind_d    = C_SUB;
          cnt_d     = CNT_W'(MULT_CYCLES);
          state_d   = S_RUN;
        end
`endif
        OP_MTHI: hi_d = rs;
        OP_MTLO: lo_d = rs;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      kind_q    <= C_WRITE;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      kind_q    <= kind_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected {hi,lo} commits.
// Exercises MDU_MADD_EN paths when that macro is defined.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] K_NONE  = 4'd0;
  localparam logic [3:0] K_MULT  = 4'd1;
  localparam logic [3:0] K_MULTU = 4'd2;
  localparam logic [3:0] K_DIV   = 4'd3;
  localparam logic [3:0] K_DIVU  = 4'd4;
  localparam logic [3:0] K_MTHI  = 4'd5;
  localparam logic [3:0] K_MTLO  = 4'd6;
  localparam logic [3:0] K_MADD  = 4'd7;
  localparam logic [3:0] K_MADDU = 4'd8;
  localparam logic [3:0] K_MSUB  = 4'd9;
  localparam logic [3:0] K_MSUBU = 4'd10;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        start;
  logic        flush;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          failures;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] exp_v;
  int          cyc;

  mdu_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .start (start),
    .flush (flush),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic is_multi(input logic [3:0] o);
    logic m;
    m = (o == K_MULT) || (o == K_MULTU) || (o == K_DIV) || (o == K_DIVU);
`ifdef MDU_MADD_EN
    m = m || (o == K_MADD) || (o == K_MADDU) || (o == K_MSUB) || (o == K_MSUBU);
`endif
    return m;
  endfunction

  function automatic int latency(input logic [3:0] o);
    return ((o == K_DIV) || (o == K_DIVU)) ? DIV_N : MULT_N;
  endfunction

  // Reference model: value {hi,lo} holds after the operation commits.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = cur;
    case (o)
      K_MULT:  p = sa * sb;
      K_MULTU: p = ua * ub;
      K_DIV:   if (b != 32'd0) begin
                 q = sa / sb;
                 r = sa % sb;
                 p = {r[31:0], q[31:0]};
               end
      K_DIVU:  if (b != 32'd0) p = {32'(ua % ub), 32'(ua / ub)};
      K_MADD:  p = cur + sa * sb;
      K_MADDU: p = cur + ua * ub;
      K_MSUB:  p = cur - sa * sb;
      K_MSUBU: p = cur - ua * ub;
      default: p = cur;
    endcase
    return p;
  endfunction

  // Drives an operation for the current cycle and updates the scoreboard/model.
  task automatic present(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic f);
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    flush = f;
    if (!f) begin
      if (is_multi(o)) begin
        exp_v = model(o, a, b, {m_hi, m_lo});
        sb_q.push_back(exp_v);
        {m_hi, m_lo} = exp_v;
      end else if (o == K_MTHI) begin
        m_hi = a;
      end else if (o == K_MTLO) begin
        m_lo = a;
      end
    end
  endtask

  // Waits past the accepting edge and scrambles operands to prove they were latched.
  task automatic release_inputs();
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    op    = K_NONE;
    rs    = $urandom;
    rt    = $urandom;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = K_NONE;
    rs    = '0;
    rt    = '0;
    m_hi  = '0;
    m_lo  = '0;
    #3;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++;
    if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_multi(input string name, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b);
    @(negedge clk);
    present(o, a, b, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL %s_stall_start: got %b want 1", name, stall); end
    release_inputs();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL %s_stall_run: got %b want 1", name, stall); end
    count_busy(cyc);
    checks++;
    if (cyc != latency(o)) begin failures++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, cyc, latency(o)); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    checks++;
    if ({hi, lo} !== exp_v) begin failures++; $display("FAIL %s_result: got %h want %h", name, {hi, lo}, exp_v); end
  endtask

  task automatic test_mult();
    run_multi("mult", K_MULT, 32'hFFFF_FFFE, 32'd3);
    run_multi("multu", K_MULTU, 32'hFFFF_FFFE, 32'd3);
  endtask

  task automatic test_div();
    run_multi("div", K_DIV, 32'hFFFF_FFF9, 32'd2);
    run_multi("divu_zero", K_DIVU, 32'd7, 32'd0);
    run_multi("div_ovf", K_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_mt_flush();
    @(negedge clk);
    present(K_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mthi_flush_stall: got %b want 0", stall); end
    release_inputs();
    checks++;
    if (hi !== m_hi) begin failures++; $display("FAIL mthi_flush_hi: got %h want %h", hi, m_hi); end
    present(K_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    release_inputs();
    checks++;
    if (hi !== m_hi || busy !== 1'b0) begin failures++; $display("FAIL mthi_write: got hi=%h busy=%b want hi=%h busy=0", hi, busy, m_hi); end
    present(K_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    release_inputs();
    checks++;
    if (lo !== m_lo || hi !== m_hi) begin failures++; $display("FAIL mtlo_write: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
    present(K_MULT, 32'd5, 32'd6, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mult_flush_stall: got %b want 0", stall); end
    release_inputs();
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL mult_flush_noop: got busy=%b hilo=%h want busy=0 hilo=%h", busy, {hi, lo}, {m_hi, m_lo}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    present(K_MULT, 32'h0001_0003, 32'hFFFF_0005, 1'b0);
    release_inputs();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_last_busy: got %b want 1", busy); end
    present(K_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);
    release_inputs();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_gap: got %b want 1", busy); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    checks++;
    if ({hi, lo} !== exp_v) begin failures++; $display("FAIL b2b_mult_result: got %h want %h", {hi, lo}, exp_v); end
    count_busy(cyc);
    checks++;
    if (cyc != DIV_N) begin failures++; $display("FAIL b2b_div_cycles: got %0d want %0d", cyc, DIV_N); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    checks++;
    if ({hi, lo} !== exp_v) begin failures++; $display("FAIL b2b_div_result: got %h want %h", {hi, lo}, exp_v); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    present(K_DIV, 32'd100, 32'd7, 1'b0);
    release_inputs();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_abort: got busy=%b hilo=%h want busy=0 hilo=0", busy, {hi, lo}); end
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (DIV_N + 5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_no_commit: got busy=%b hilo=%h want busy=0 hilo=0", busy, {hi, lo}); end
  endtask

  task automatic test_madd();
    @(negedge clk);
    present(K_MTHI, 32'd0, 32'd0, 1'b0);
    release_inputs();
    present(K_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    release_inputs();
`ifdef MDU_MADD_EN
    present(K_MADDU, 32'd1, 32'd1, 1'b0);
    release_inputs();
    count_busy(cyc);
    checks++;
    if (cyc != MULT_N) begin failures++; $display("FAIL maddu_cycles: got %0d want %0d", cyc, MULT_N); end
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    checks++;
    if ({hi, lo} !== exp_v) begin failures++; $display("FAIL maddu_result: got %h want %h", {hi, lo}, exp_v); end
    run_multi("msub", K_MSUB, 32'd2, 32'd3);
    run_multi("madd", K_MADD, 32'hFFFF_FFFF, 32'd9);
    run_multi("msubu", K_MSUBU, 32'hFFFF_FFFF, 32'd2);
`else
    present(K_MADDU, 32'd1, 32'd1, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL maddu_off_stall: got %b want 0", stall); end
    release_inputs();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL maddu_off_busy: got %b want 0", busy); end
    repeat (MULT_N + 1) @(negedge clk);
    checks++;
    if ({hi, lo} !== {m_hi, m_lo}) begin failures++; $display("FAIL maddu_off_hilo: got %h want %h", {hi, lo}, {m_hi, m_lo}); end
`endif
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       o = K_MULT;
        1:       o = K_MULTU;
        2:       o = K_DIV;
        default: o = K_DIVU;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_multi("random", o, a, b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_div();
    test_mt_flush();
    test_back_to_back();
    test_reset_mid_run();
    test_madd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
